// File: rtl/collision_judge.sv
// Shot judge: sweeps a target left/right, scores each landing point against it
// and holds the ball at the landing spot for a fixed number of frames.
module collision_judge #(
  parameter int TGT_XMIN    = -100,
  parameter int TGT_XMAX    = 100,
  parameter int TGT_Y       = 150,
  parameter int TGT_STEP    = 2,
  parameter int RADIUS      = 16,
  parameter int HOLD_FRAMES = 90
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_refresh,
  input  logic               i_mouse_left,
  input  logic signed [12:0] i_x_pos,
  input  logic signed [12:0] i_y_pos,
  input  logic               i_z_neg,
  output logic               o_en_collision,
  output logic               o_collision_done,
  output logic               o_hit,
  output logic        [6:0]  o_score,
  output logic signed [12:0] o_tgt_x
);

  localparam int unsigned POS_W   = 13;
  localparam int unsigned DIF_W   = 14;
  localparam int unsigned SCORE_W = 7;
  localparam int unsigned CNT_W   = $clog2(HOLD_FRAMES + 1);

  localparam logic [SCORE_W-1:0]      SCORE_MAX = SCORE_W'(99);
  localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLD_FRAMES);
  localparam logic signed [DIF_W-1:0] RAD_HI    = DIF_W'(RADIUS);
  localparam logic signed [DIF_W-1:0] RAD_LO    = DIF_W'(-RADIUS);
  localparam logic signed [DIF_W-1:0] STEP_P    = DIF_W'(TGT_STEP);
  localparam logic signed [DIF_W-1:0] STEP_N    = DIF_W'(-TGT_STEP);
  localparam logic signed [DIF_W-1:0] XMAX_D    = DIF_W'(TGT_XMAX);
  localparam logic signed [DIF_W-1:0] XMIN_D    = DIF_W'(TGT_XMIN);
  localparam logic signed [DIF_W-1:0] TY_D      = DIF_W'(TGT_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLIGHT,
    S_EVAL,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic                     first_cyc, first_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt, cnt_inc;
  logic signed [POS_W-1:0]  land_x, land_y, land_x_nxt, land_y_nxt;
  logic signed [POS_W-1:0]  tgt_x, tgt_nxt;
  logic                     dir_neg, dir_nxt;
  logic                     abort;
  logic                     hit_calc, hit_nxt, en_nxt, done_nxt;
  logic [SCORE_W-1:0]       score_nxt;
  logic signed [DIF_W-1:0]  dx, dy, tgt_sum;

  // Next-state: a mouse press outside IDLE always restarts the flight.
  always_comb begin
    state_nxt  = state;
    abort      = 1'b0;
    cnt_inc    = cnt + CNT_W'(1);
    cnt_nxt    = cnt;
    land_x_nxt = land_x;
    land_y_nxt = land_y;
    case (state)
      S_IDLE: begin
        if (i_mouse_left) state_nxt = S_FLIGHT;
      end
      S_FLIGHT: begin
        if (i_mouse_left) begin
          abort = 1'b1;
        end else if (!first_cyc && i_z_neg) begin
          state_nxt  = S_EVAL;
          land_x_nxt = i_x_pos;
          land_y_nxt = i_y_pos;
        end
      end
      S_EVAL: begin
        if (i_mouse_left) abort = 1'b1;
        else              state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_mouse_left) begin
          abort = 1'b1;
        end else if (i_refresh) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == HOLD_LAST) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_mouse_left) abort = 1'b1;
        else              state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_FLIGHT;
    if (state_nxt != S_HOLD) cnt_nxt = '0;
    // The previous shot may still report z_neg on the first flight cycle.
    first_nxt = (state_nxt == S_FLIGHT) && ((state != S_FLIGHT) || abort);
  end

  // Hit test, score and target motion; differences at 14 bits cannot wrap.
  always_comb begin
    dx       = {land_x[POS_W-1], land_x} - {tgt_x[POS_W-1], tgt_x};
    dy       = {land_y[POS_W-1], land_y} - TY_D;
    hit_calc = (dx <= RAD_HI) && (dx >= RAD_LO) && (dy <= RAD_HI) && (dy >= RAD_LO);

    hit_nxt   = o_hit;
    score_nxt = o_score;
    if ((state == S_EVAL) && !abort) begin
      hit_nxt = hit_calc;
      if (hit_calc && (o_score < SCORE_MAX)) score_nxt = o_score + SCORE_W'(1);
    end
    en_nxt   = (state_nxt == S_HOLD) && hit_nxt;
    done_nxt = (state_nxt == S_DONE);

    tgt_sum = {tgt_x[POS_W-1], tgt_x} + (dir_neg ? STEP_N : STEP_P);
    tgt_nxt = tgt_x;
    dir_nxt = dir_neg;
    if (i_refresh && ((state == S_IDLE) || (state == S_FLIGHT))) begin
      if (tgt_sum >= XMAX_D) begin
        tgt_nxt = POS_W'(TGT_XMAX);
        dir_nxt = 1'b1;
      end else if (tgt_sum <= XMIN_D) begin
        tgt_nxt = POS_W'(TGT_XMIN);
        dir_nxt = 1'b0;
      end else begin
        tgt_nxt = tgt_sum[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      first_cyc        <= 1'b0;
      cnt              <= '0;
      land_x           <= '0;
      land_y           <= '0;
      tgt_x            <= '0;
      dir_neg          <= 1'b0;
      o_en_collision   <= 1'b0;
      o_collision_done <= 1'b0;
      o_hit            <= 1'b0;
      o_score          <= '0;
    end else begin
      state            <= state_nxt;
      first_cyc        <= first_nxt;
      cnt              <= cnt_nxt;
      land_x           <= land_x_nxt;
      land_y           <= land_y_nxt;
      tgt_x            <= tgt_nxt;
      dir_neg          <= dir_nxt;
      o_en_collision   <= en_nxt;
      o_collision_done <= done_nxt;
      o_hit            <= hit_nxt;
      o_score          <= score_nxt;
    end
  end

  assign o_tgt_x = tgt_x;

endmodule

// File: tb/tb_collision_judge.sv
// Bench for collision_judge: table of landing points plus directed sequences,
// with end-of-shot results checked from a scoreboard queue.
module tb_collision_judge;
  localparam int HOLD = 90;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               refresh;
  logic               mouse;
  logic signed [12:0] x_pos;
  logic signed [12:0] y_pos;
  logic               z_neg;
  logic               en_collision;
  logic               collision_done;
  logic               hit;
  logic        [6:0]  score;
  logic signed [12:0] tgt_x;

  always #5 clk = ~clk;

  collision_judge dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_refresh       (refresh),
    .i_mouse_left    (mouse),
    .i_x_pos         (x_pos),
    .i_y_pos         (y_pos),
    .i_z_neg         (z_neg),
    .o_en_collision  (en_collision),
    .o_collision_done(collision_done),
    .o_hit           (hit),
    .o_score         (score),
    .o_tgt_x         (tgt_x)
  );

  typedef struct { bit hit; int score; int en_refr; } exp_t;
  typedef struct { int x; int y; bit hit; } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_score = 0;
  bit   last_hit  = 1'b0;
  int   en_cnt    = 0;
  int   done_seen = 0;
  bit   done_prev = 1'b0;
  int   d0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    tick();
  endtask

  // End-of-shot monitor: pops the expected record on every done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      en_cnt    = 0;
      done_prev = 1'b0;
    end else begin
      if (mouse) en_cnt = 0;
      else if (refresh && en_collision) en_cnt++;
      if (done_prev) chk("done_width", collision_done, 0);
      if (collision_done) begin
        done_seen++;
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_hit", hit, e.hit);
          chk("sb_score", score, e.score);
          chk("sb_en_refreshes", en_cnt, e.en_refr);
        end
        en_cnt = 0;
      end
      done_prev = collision_done;
    end
  end

  // Launch (or relaunch), land at (x,y) and check the evaluation result.
  task automatic land_shot(input bit launch, input int x, input int y, input bit h,
                           input bit abort_eval, input bit push);
    int s0;
    s0 = exp_score;
    if (launch) begin
      mouse = 1'b1;
      tick();
      mouse = 1'b0;
    end
    x_pos = 13'(x);
    y_pos = 13'(y);
    z_neg = 1'b1;
    tick();
    tick();
    z_neg = 1'b0;
    chk("eval_score", score, s0);
    chk("eval_en", en_collision, 0);
    if (abort_eval) begin
      mouse = 1'b1;
      tick();
      mouse = 1'b0;
      chk("abort_eval_en", en_collision, 0);
      chk("abort_eval_hit", hit, last_hit);
      chk("abort_eval_score", score, exp_score);
    end else begin
      if (h && exp_score < 99) exp_score++;
      last_hit = h;
      if (push) sb.push_back('{h, exp_score, h ? HOLD : 0});
      tick();
      chk("shot_hit", hit, h);
      chk("shot_score", score, exp_score);
      chk("shot_en", en_collision, h);
    end
  endtask

  task automatic finish_hold(input bit h);
    int n0;
    n0 = done_seen;
    repeat (HOLD - 1) pulse_refresh();
    chk("hold_en", en_collision, h);
    chk("hold_no_early_done", done_seen - n0, 0);
    pulse_refresh();
    chk("done_pulse", done_seen - n0, 1);
    chk("post_en", en_collision, 0);
    chk("post_done", collision_done, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{10, 150, 1'b1};
    vecs[1]  = '{40, 150, 1'b0};
    vecs[2]  = '{16, 150, 1'b1};
    vecs[3]  = '{17, 150, 1'b0};
    vecs[4]  = '{-16, 150, 1'b1};
    vecs[5]  = '{-17, 150, 1'b0};
    vecs[6]  = '{0, 166, 1'b1};
    vecs[7]  = '{0, 167, 1'b0};
    vecs[8]  = '{0, 134, 1'b1};
    vecs[9]  = '{0, 133, 1'b0};
    vecs[10] = '{16, 166, 1'b1};
    vecs[11] = '{-4096, -4096, 1'b0};

    rst_n = 1'b0; refresh = 1'b0; mouse = 1'b0; z_neg = 1'b0;
    x_pos = '0; y_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en_collision, 0);
    chk("rst_done", collision_done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_score", score, 0);
    chk("rst_tgt", tgt_x, 0);
    rst_n = 1'b1;

    // Landing indications alone must not leave IDLE.
    x_pos = 13'(0); y_pos = 13'(150); z_neg = 1'b1;
    repeat (6) tick();
    z_neg = 1'b0;
    chk("idle_en", en_collision, 0);
    chk("idle_score", score, 0);

    for (int i = 0; i < 12; i++) begin
      land_shot(1'b1, vecs[i].x, vecs[i].y, vecs[i].hit, 1'b0, 1'b1);
      finish_hold(vecs[i].hit);
    end

    // Abort at HOLD refresh 30 after a hit.
    land_shot(1'b1, 10, 150, 1'b1, 1'b0, 1'b0);
    repeat (30) pulse_refresh();
    d0 = done_seen;
    mouse = 1'b1;
    tick();
    mouse = 1'b0;
    chk("abort_en", en_collision, 0);
    chk("abort_hit", hit, 1);
    chk("abort_score", score, exp_score);
    repeat (5) begin
      tick();
      chk("abort_no_done", collision_done, 0);
    end
    chk("abort_done_count", done_seen - d0, 0);
    land_shot(1'b1, 40, 150, 1'b0, 1'b0, 1'b1);
    finish_hold(1'b0);

    // Abort during EVAL: no score change, hit keeps the previous miss.
    land_shot(1'b1, 0, 150, 1'b1, 1'b1, 1'b0);
    land_shot(1'b0, 0, 150, 1'b1, 1'b0, 1'b1);
    finish_hold(1'b1);

    // Target bounce and freeze.
    repeat (50) pulse_refresh();
    chk("tgt_at_max", tgt_x, 100);
    pulse_refresh();
    chk("tgt_reverse", tgt_x, 98);
    mouse = 1'b1; refresh = 1'b1;
    tick();
    mouse = 1'b0; refresh = 1'b0;
    chk("tgt_launch_edge", tgt_x, 96);
    x_pos = 13'(110); y_pos = 13'(150); z_neg = 1'b1;
    tick();
    refresh = 1'b1;
    tick();
    z_neg = 1'b0;
    chk("tgt_land_edge", tgt_x, 94);
    if (exp_score < 99) exp_score++;
    last_hit = 1'b1;
    sb.push_back('{1'b1, exp_score, HOLD});
    tick();
    refresh = 1'b0;
    chk("tgt_eval_frozen", tgt_x, 94);
    chk("bounce_hit", hit, 1);
    chk("bounce_en", en_collision, 1);
    chk("bounce_score", score, exp_score);
    finish_hold(1'b1);
    chk("tgt_hold_frozen", tgt_x, 94);
    pulse_refresh();
    chk("tgt_resume", tgt_x, 92);

    // Reset asserted mid-HOLD, away from any clock edge.
    land_shot(1'b1, 92, 150, 1'b1, 1'b0, 1'b0);
    repeat (20) pulse_refresh();
    chk("pre_rst_en", en_collision, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", en_collision, 0);
    chk("async_rst_done", collision_done, 0);
    chk("async_rst_hit", hit, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_tgt", tgt_x, 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_score = 0;
    last_hit  = 1'b0;
    d0 = done_seen;
    repeat (10) tick();
    chk("post_rst_no_done", done_seen - d0, 0);
    chk("post_rst_en", en_collision, 0);

    // Saturation: 100 hits stop the score at 99.
    for (int i = 0; i < 100; i++) begin
      land_shot(1'b1, 0, 150, 1'b1, 1'b0, 1'b1);
      finish_hold(1'b1);
    end
    chk("score_saturated", score, 99);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/collision_judge.md
COLLISION_JUDGE -- requirements
Module: collision_judge

Parameters
REQ-001 The block SHALL declare these parameters (name, default, meaning):
- TGT_XMIN, -100: left bound of target centre X (signed 13-bit).
- TGT_XMAX, 100: right bound of target centre X.
- TGT_Y, 150: fixed target centre Y.
- TGT_STEP, 2: target X step per refresh.
- RADIUS, 16: hit half-width, applied to X and Y separately.
- HOLD_FRAMES, 90: refresh pulses held after landing; must be greater than 60.

Interface
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1: the only clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_refresh, in, 1: one-cycle frame pulse, synchronous to i_clk.
- i_mouse_left, in, 1: launch/relaunch request, level.
- i_x_pos, in, 13 signed: ball screen X from the flight model.
- i_y_pos, in, 13 signed: ball screen Y from the flight model.
- i_z_neg, in, 1: ball has landed (height < 0).
- o_en_collision, out, 1: hold ball at landing point.
- o_collision_done, out, 1: one-cycle end-of-shot pulse; clears the flight model.
- o_hit, out, 1: last shot was a hit.
- o_score, out, 7: hit count, 0..99.
- o_tgt_x, out, 13 signed: current target centre X, used for rendering.

Function
REQ-003 The FSM SHALL have the states IDLE, FLIGHT, EVAL, HOLD and DONE, all registered on posedge i_clk.
REQ-004 IDLE: i_mouse_left=1 SHALL move the FSM to FLIGHT on the next edge.
REQ-005 FLIGHT: on the first cycle in FLIGHT, i_z_neg SHALL be ignored.
REQ-006 FLIGHT: on later cycles, i_z_neg=1 SHALL latch i_x_pos/i_y_pos into land_x/land_y and move the FSM to EVAL on the same edge.
REQ-007 EVAL SHALL last exactly one cycle, then move to HOLD.
REQ-008 In EVAL, o_hit SHALL be registered as 1 iff |land_x - tgt_x| <= RADIUS and |land_y - TGT_Y| <= RADIUS.
REQ-009 The differences in REQ-008 SHALL be computed at 14-bit signed width, so they cannot overflow.
REQ-010 On a hit, o_score SHALL increment on the EVAL-to-HOLD edge, saturating at 99.
REQ-011 HOLD SHALL count i_refresh pulses from 0.
REQ-012 When the HOLD count reaches HOLD_FRAMES, the FSM SHALL move to DONE.
REQ-013 o_en_collision SHALL be registered and equal 1 exactly while state==HOLD and o_hit==1.
REQ-014 DONE SHALL last one cycle, during which o_collision_done=1; the FSM then returns to IDLE.
REQ-015 o_collision_done SHALL be 0 in every other state.
REQ-016 In FLIGHT, EVAL, HOLD or DONE, i_mouse_left=1 SHALL abort the shot.
REQ-017 An abort SHALL move the FSM to FLIGHT next edge, clear the hold count, force o_en_collision=0 and suppress the DONE pulse.
REQ-018 An abort SHALL leave o_score and o_hit unchanged.
REQ-019 If an EVAL cycle is aborted, no score increment SHALL occur.
REQ-020 On each i_refresh in IDLE or FLIGHT, tgt_x SHALL move by TGT_STEP in the current direction.
REQ-021 If tgt_x would pass TGT_XMAX or TGT_XMIN, it SHALL be clamped to that bound and the direction reversed on the same edge.
REQ-022 tgt_x SHALL be frozen in EVAL, HOLD and DONE.
REQ-023 i_refresh coincident with a state transition SHALL be applied according to the state before the edge.
REQ-024 o_tgt_x SHALL be driven directly from the tgt_x register.

Reset
REQ-025 While i_rst_n=0, the block SHALL force, asynchronously: state=IDLE, hold count=0, land_x=land_y=0, tgt_x=0, direction=+, o_en_collision=0, o_collision_done=0, o_hit=0, o_score=0.
REQ-026 Reset asserted mid-HOLD SHALL drop o_en_collision immediately, with no DONE pulse.
REQ-027 After reset release, the FSM SHALL leave IDLE only on i_mouse_left.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Hit: tgt_x=0, launch, land (10,150) -> o_hit=1, score 0->1, o_en_collision=1 for 90 refreshes, then one-cycle o_collision_done, IDLE.
- Miss: land (40,150) with tgt_x=0 -> o_hit=0, o_en_collision stays 0, done pulse after 90 refreshes, score unchanged.
- Edge: land_x = tgt_x+16 -> hit; land_x = tgt_x+17 -> miss; the same for Y = 166 and 167.
- Target bounce: 50 refreshes in IDLE from reset -> tgt_x=100; 1 more -> 98; freeze verified across EVAL/HOLD.
- Abort: i_mouse_left at HOLD refresh 30 after a hit -> FLIGHT next cycle, o_en_collision=0, no done pulse, score stays 1.
- Saturation/reset: 100 hits -> o_score=99; i_rst_n low mid-HOLD -> all outputs 0 asynchronously.
